// File: rtl/syndrome_ingress_packer.sv
// ---------------------------------------------------------------------------
// syndrome_ingress_packer
//
// Host-side ingress stage in front of the decoder core's 32-bit
// input_data/input_valid/input_ready port. One handshake on the measurement
// side delivers a complete round of syndrome bits. The round is serialised
// into a frame of one header word followed by NUM_WORDS payload words. Each
// frame is tagged with the round index within the decoding block and with the
// decoding context index.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   meas_data      one round of measurement bits, bit i = PU i
//   meas_valid     meas_data is valid
//   meas_ready     packer accepts a round this cycle
//   output_data    framed word towards the core
//   output_valid   output_data is valid
//   output_ready   core accepts the current word
//   round_index    round number the next accepted round will carry
//   context_index  context number the next accepted round will carry
//   busy           high whenever a frame is in flight (FSM not IDLE)
//
// Header word
//   [31:28] 1 = normal round, 2 = last round of the decoding block
//   [27:24] FPGA_ID
//   [23:16] captured round index
//   [15:8]  captured context index
//   [7:0]   NUM_WORDS
//
// Parameter limits: GRID_WIDTH_U <= 256, NUM_CONTEXTS <= 256, FPGA_ID <= 15,
// NUM_WORDS <= 255.
// ---------------------------------------------------------------------------
module syndrome_ingress_packer #(
  parameter int GRID_WIDTH_X = 12,
  parameter int GRID_WIDTH_Z = 2,
  parameter int GRID_WIDTH_U = 10,
  parameter int NUM_CONTEXTS = 2,
  parameter int FPGA_ID      = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [GRID_WIDTH_X*GRID_WIDTH_Z-1:0] meas_data,
  input  logic                                 meas_valid,
  output logic                                 meas_ready,
  output logic [31:0]                          output_data,
  output logic                                 output_valid,
  input  logic                                 output_ready,
  output logic [7:0]                           round_index,
  output logic [7:0]                           context_index,
  output logic                                 busy
);

  localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int NUM_WORDS          = (PU_COUNT_PER_ROUND + 31) / 32;
  localparam int CAP_WIDTH          = NUM_WORDS * 32;
  localparam int CNT_WIDTH          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CNT_WIDTH-1:0] LAST_WORD      = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [7:0]           LAST_ROUND     = 8'(GRID_WIDTH_U - 1);
  localparam logic [7:0]           LAST_CONTEXT   = 8'(NUM_CONTEXTS - 1);
  localparam logic [3:0]           FPGA_TAG       = 4'(FPGA_ID);
  localparam logic [7:0]           WORD_COUNT_TAG = 8'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Captured round, zero-extended to a whole number of 32-bit words so the
  // padding of the last payload word falls out naturally.
  logic [CAP_WIDTH-1:0] capture;
  logic [7:0]           cap_round;
  logic [7:0]           cap_context;
  logic [CNT_WIDTH-1:0] word_cnt;

  logic                 last_beat;
  logic                 round_done;
  logic                 meas_accept;
  logic [7:0]           next_round;
  logic [7:0]           next_context;
  logic [7:0]           tag_round;
  logic [7:0]           tag_context;
  logic [31:0]          header_word;
  logic [31:0]          payload_word;

  // The round completes when the final payload word is taken by the core.
  assign last_beat   = (state == PAYLOAD) && (word_cnt == LAST_WORD);
  assign round_done  = last_beat && output_ready;
  assign meas_accept = meas_valid && meas_ready;

  // Round/context values after the current round completes. A round that is
  // accepted in the same cycle as a completion must carry these updated values,
  // so tag_* selects between the live registers and their successors.
  always_comb begin
    next_round   = round_index + 8'd1;
    next_context = context_index;
    if (round_index == LAST_ROUND) begin
      next_round   = 8'd0;
      next_context = (context_index == LAST_CONTEXT) ? 8'd0 : context_index + 8'd1;
    end
    tag_round   = round_done ? next_round   : round_index;
    tag_context = round_done ? next_context : context_index;
  end

  // Header built purely from captured registers, so output_data never depends
  // combinationally on output_ready.
  always_comb begin
    header_word = {(cap_round == LAST_ROUND) ? 4'h2 : 4'h1,
                   FPGA_TAG, cap_round, cap_context, WORD_COUNT_TAG};
  end

  // Word select out of the capture register.
  always_comb begin
    payload_word = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (word_cnt == CNT_WIDTH'(w)) begin
        payload_word = capture[32*w +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A round accepted on the final payload beat goes straight
  // back to HEADER, which keeps consecutive frames gap-free.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (meas_accept) begin
          next_state = HEADER;
        end
      end
      HEADER: begin
        if (output_ready) begin
          next_state = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (round_done) begin
          next_state = meas_accept ? HEADER : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output logic. meas_ready is held low while reset is asserted so no round
  // can be taken in the reset cycle.
  always_comb begin
    output_valid = 1'b0;
    output_data  = 32'd0;
    meas_ready   = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        meas_ready = !reset;
      end
      HEADER: begin
        output_valid = 1'b1;
        output_data  = header_word;
        busy         = 1'b1;
      end
      PAYLOAD: begin
        output_valid = 1'b1;
        output_data  = payload_word;
        busy         = 1'b1;
        meas_ready   = !reset && round_done;
      end
      default: begin
        output_valid = 1'b0;
      end
    endcase
  end

  // Capture, word counter and round/context bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture       <= '0;
      cap_round     <= 8'd0;
      cap_context   <= 8'd0;
      word_cnt      <= '0;
      round_index   <= 8'd0;
      context_index <= 8'd0;
    end else begin
      if (meas_accept) begin
        capture     <= CAP_WIDTH'(meas_data);
        cap_round   <= tag_round;
        cap_context <= tag_context;
      end
      if (round_done) begin
        round_index   <= next_round;
        context_index <= next_context;
      end
      if ((state == HEADER) && output_ready) begin
        word_cnt <= '0;
      end else if ((state == PAYLOAD) && output_ready && !last_beat) begin
        word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_syndrome_ingress_packer.sv
// ---------------------------------------------------------------------------
// tb_syndrome_ingress_packer
//
// Two packer instances share one stimulus bus: dut_a uses the default
// geometry (24 bits, one payload word), dut_b a 40-bit geometry (two payload
// words, 3 rounds per block). A select flag picks whose outputs are checked.
// The reference model is a word-level queue of expected frame words plus the
// round/context counters, updated from the framing rules only.
// ---------------------------------------------------------------------------
module tb_syndrome_ingress_packer;

  logic        clk;
  logic        reset;
  logic [39:0] meas_data;
  logic        meas_valid;
  logic        output_ready;
  logic        sel;

  logic        a_mready, a_valid, a_busy;
  logic [31:0] a_data;
  logic [7:0]  a_round, a_ctx;
  logic        b_mready, b_valid, b_busy;
  logic [31:0] b_data;
  logic [7:0]  b_round, b_ctx;

  logic        obs_mready, obs_valid, obs_busy;
  logic [31:0] obs_data;
  logic [7:0]  obs_round, obs_ctx;

  syndrome_ingress_packer dut_a (
    .clk           (clk),
    .reset         (reset),
    .meas_data     (meas_data[23:0]),
    .meas_valid    (meas_valid),
    .meas_ready    (a_mready),
    .output_data   (a_data),
    .output_valid  (a_valid),
    .output_ready  (output_ready),
    .round_index   (a_round),
    .context_index (a_ctx),
    .busy          (a_busy)
  );

  syndrome_ingress_packer #(
    .GRID_WIDTH_X (20),
    .GRID_WIDTH_Z (2),
    .GRID_WIDTH_U (3),
    .NUM_CONTEXTS (2),
    .FPGA_ID      (3)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .meas_data     (meas_data),
    .meas_valid    (meas_valid),
    .meas_ready    (b_mready),
    .output_data   (b_data),
    .output_valid  (b_valid),
    .output_ready  (output_ready),
    .round_index   (b_round),
    .context_index (b_ctx),
    .busy          (b_busy)
  );

  assign obs_mready = sel ? b_mready : a_mready;
  assign obs_valid  = sel ? b_valid  : a_valid;
  assign obs_busy   = sel ? b_busy   : a_busy;
  assign obs_data   = sel ? b_data   : a_data;
  assign obs_round  = sel ? b_round  : a_round;
  assign obs_ctx    = sel ? b_ctx    : a_ctx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] wq[$];
  bit          lq[$];
  int          m_round;
  int          m_ctx;
  int          cfg_bits, cfg_nw, cfg_u, cfg_c, cfg_fpga;
  bit          just_reset;

  int n_checks;
  int n_fail;

  logic [31:0] seen_d;
  logic        seen_v;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic advanceRound();
    if (m_round == cfg_u - 1) begin
      m_round = 0;
      m_ctx   = (m_ctx == cfg_c - 1) ? 0 : m_ctx + 1;
    end else begin
      m_round = m_round + 1;
    end
  endtask

  task automatic pushFrame(input logic [39:0] d);
    logic [63:0] wide;
    logic [63:0] sh;
    logic [3:0]  kind;
    wide = {24'd0, d} & ((64'd1 << cfg_bits) - 64'd1);
    kind = (m_round == cfg_u - 1) ? 4'h2 : 4'h1;
    wq.push_back({kind, 4'(cfg_fpga), 8'(m_round), 8'(m_ctx), 8'(cfg_nw)});
    lq.push_back(1'b0);
    for (int w = 0; w < cfg_nw; w++) begin
      sh = wide >> (32 * w);
      wq.push_back(sh[31:0]);
      lq.push_back(w == cfg_nw - 1);
    end
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, advance the
  // model by what the rising edge will do.
  task automatic applyStimulus(input logic rst, input logic mv, input logic [39:0] md,
                               input logic ordy, output logic [31:0] sd, output logic sv);
    logic exp_mready;
    logic exp_busy;
    bit   last;
    @(negedge clk);
    reset        = rst;
    meas_valid   = mv;
    meas_data    = md;
    output_ready = ordy;
    #1;
    sd = obs_data;
    sv = obs_valid;
    exp_busy   = (wq.size() != 0);
    exp_mready = !rst && ((wq.size() == 0) || (wq.size() == 1 && ordy));
    checkOutput("meas_ready", 32'(obs_mready), 32'(exp_mready));
    if (!rst) begin
      checkOutput("output_valid", 32'(obs_valid), 32'(exp_busy));
      checkOutput("busy", 32'(obs_busy), 32'(exp_busy));
      checkOutput("round_index", 32'(obs_round), 32'(m_round));
      checkOutput("context_index", 32'(obs_ctx), 32'(m_ctx));
      if (exp_busy) checkOutput("output_data", obs_data, wq[0]);
      else if (just_reset) checkOutput("reset_data", obs_data, 32'd0);
      just_reset = 1'b0;
      if (exp_busy && ordy) begin
        last = lq.pop_front();
        void'(wq.pop_front());
        if (last) advanceRound();
      end
      if (mv && exp_mready) pushFrame(md);
    end else begin
      wq.delete();
      lq.delete();
      m_round    = 0;
      m_ctx      = 0;
      just_reset = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic step(input logic rst, input logic mv, input logic [39:0] md, input logic ordy);
    logic [31:0] d;
    logic        v;
    applyStimulus(rst, mv, md, ordy, d, v);
  endtask

  // Bounded drain; an expired budget shows up as output_valid still high.
  task automatic drain();
    for (int i = 0; i < 20 && wq.size() != 0; i++) step(1'b0, 1'b0, rnd40(), 1'b1);
    #1;
    checkOutput("drain_idle", 32'(obs_valid), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    meas_valid   = 1'b0;
    meas_data    = '0;
    output_ready = 1'b0;
    m_round      = 0;
    m_ctx        = 0;
    just_reset   = 1'b0;

    // ---------------- dut_a: defaults ----------------
    sel = 1'b0; cfg_bits = 24; cfg_nw = 1; cfg_u = 10; cfg_c = 2; cfg_fpga = 1;
    $display("[TB] phase A: 24-bit default geometry");
    step(1'b1, 1'b1, rnd40(), 1'b1);
    step(1'b1, 1'b0, rnd40(), 1'b0);

    applyStimulus(1'b0, 1'b1, 40'h00_00AB_CDEF, 1'b1, seen_d, seen_v);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("first_header", seen_d, 32'h1100_0001);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("first_payload", seen_d, 32'h00AB_CDEF);
    #1;
    checkOutput("round_after_first", 32'(obs_round), 32'd1);

    // Nine more rounds with meas_valid held high, then the tenth header.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, rnd40(), 1'b1);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("tenth_header", seen_d, 32'h2109_0001);
    step(1'b0, 1'b0, rnd40(), 1'b1);
    #1;
    checkOutput("block_round_wrap", 32'(obs_round), 32'd0);
    checkOutput("block_ctx_step", 32'(obs_ctx), 32'd1);

    // Header held under backpressure.
    step(1'b0, 1'b1, rnd40(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd40(), 1'b0);
    drain();

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom), rnd40(), 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset while in PAYLOAD.
    step(1'b0, 1'b1, rnd40(), 1'b1);
    step(1'b0, 1'b0, rnd40(), 1'b1);
    step(1'b1, 1'b0, rnd40(), 1'b0);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("post_reset_valid", 32'(seen_v), 32'd0);
    step(1'b0, 1'b1, 40'h00_0012_3456, 1'b1);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("post_reset_header", seen_d, 32'h1100_0001);
    drain();

    // ---------------- dut_b: 40 bits, two payload words ----------------
    sel = 1'b1; cfg_bits = 40; cfg_nw = 2; cfg_u = 3; cfg_c = 2; cfg_fpga = 3;
    $display("[TB] phase B: 40-bit geometry");
    step(1'b1, 1'b0, rnd40(), 1'b0);
    step(1'b1, 1'b0, rnd40(), 1'b0);

    applyStimulus(1'b0, 1'b1, 40'hFF_1234_5678, 1'b1, seen_d, seen_v);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("wide_header", seen_d, 32'h1300_0002);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("wide_word0", seen_d, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, rnd40(), 1'b1, seen_d, seen_v);
    checkOutput("wide_word1", seen_d, 32'h0000_00FF);

    // Mid-frame backpressure with meas_valid high and changing data.
    step(1'b0, 1'b1, rnd40(), 1'b1);
    step(1'b0, 1'b1, rnd40(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd40(), 1'b0);
    step(1'b0, 1'b0, rnd40(), 1'b1);
    step(1'b0, 1'b0, rnd40(), 1'b1);
    #1;
    checkOutput("wide_round_two", 32'(obs_round), 32'd2);

    // Five back-to-back rounds: rounds 2,0,1,2 then 0 wraps context 1 -> 0.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, rnd40(), 1'b1);
    drain();
    checkOutput("ctx_wrap_round", 32'(obs_round), 32'd1);
    checkOutput("ctx_wrap_ctx", 32'(obs_ctx), 32'd0);

    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom), rnd40(), 1'($urandom_range(0, 3) != 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
